// File: rtl/nn_dense_engine.sv
// Dense-layer forward engine: per column c, z = sum_i x[c][i]*w[i] + bias,
// then identity / ReLU / hard-sigmoid activation, one result per column
// streamed over a valid/ready port. Inputs and weights come from
// synchronous ROMs with one cycle of read latency.
module nn_dense_engine #(
    parameter int N_IN  = 784,
    parameter int N_COL = 40,
    parameter int X_W   = 8,
    parameter int W_W   = 12,
    parameter int ACC_W = 32,
    parameter int OUT_W = 12,
    localparam int XA_W = (N_IN * N_COL > 1) ? $clog2(N_IN * N_COL) : 1,
    localparam int WA_W = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int C_W  = (N_COL > 1) ? $clog2(N_COL) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [W_W-1:0]   bias,
    output logic             busy,
    output logic             done,
    output logic             x_rd,
    output logic [XA_W-1:0]  x_addr,
    input  logic [X_W-1:0]   x_data,
    output logic             w_rd,
    output logic [WA_W-1:0]  w_addr,
    input  logic [W_W-1:0]   w_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [C_W-1:0]   y_col,
    output logic [OUT_W-1:0] y_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_ACT   = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [WA_W-1:0] I_LAST = WA_W'(N_IN - 1);
    localparam logic [C_W-1:0]  C_LAST = C_W'(N_COL - 1);

    // Output saturation bounds and hard-sigmoid constants (0.5 and 1.0 in Q.8)
    localparam logic signed [ACC_W-1:0] S_MAX  = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN  = ~S_MAX;
    localparam logic signed [ACC_W-1:0] H_HALF = ACC_W'(128);
    localparam logic signed [ACC_W-1:0] H_ONE  = ACC_W'(256);

    logic [2:0]              state_reg;
    logic [C_W-1:0]          c_reg;
    logic [WA_W-1:0]         i_reg;
    logic [1:0]              mode_reg;
    logic signed [W_W-1:0]   bias_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic                    rd_d_reg;
    logic                    first_d_reg;
    logic [C_W-1:0]          y_col_reg;
    logic [OUT_W-1:0]        y_data_reg;

    logic                    fetch;
    logic signed [X_W+W_W:0] prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_q;
    logic signed [ACC_W-1:0] s_val;
    logic signed [ACC_W-1:0] h_val;
    logic [OUT_W-1:0]        sat_s;
    logic [OUT_W-1:0]        y_next;

    assign fetch   = (state_reg == S_FETCH);
    assign x_rd    = fetch;
    assign w_rd    = fetch;
    assign x_addr  = fetch ? (XA_W'(c_reg) * XA_W'(N_IN) + XA_W'(i_reg)) : '0;
    assign w_addr  = fetch ? i_reg : '0;
    assign busy    = (state_reg == S_FETCH) || (state_reg == S_DRAIN) ||
                     (state_reg == S_ACT)   || (state_reg == S_OUT);
    assign done    = (state_reg == S_DONE);
    assign y_valid = (state_reg == S_OUT);
    assign y_col   = y_col_reg;
    assign y_data  = y_data_reg;

    // Unsigned sample times signed weight is exact at X_W+W_W+1 bits
    assign prod     = $signed({1'b0, x_data}) * $signed(w_data);
    assign prod_ext = {{(ACC_W - X_W - W_W - 1){prod[X_W+W_W]}}, prod};
    assign bias_q   = $signed({{(ACC_W - W_W){bias_reg[W_W-1]}}, bias_reg}) <<< 8;
    assign s_val    = acc_reg >>> 8;
    assign h_val    = H_HALF + (acc_reg >>> 10);

    // Activation: saturate Q.8 result, ReLU floor, or clamped 0.5 + z/4
    always_comb begin
        sat_s  = s_val[OUT_W-1:0];
        if (s_val > S_MAX)
            sat_s = S_MAX[OUT_W-1:0];
        else if (s_val < S_MIN)
            sat_s = S_MIN[OUT_W-1:0];
        y_next = sat_s;
        case (mode_reg)
            2'd1: y_next = (s_val < 0) ? '0 : sat_s;
            2'd2: begin
                if (h_val < 0)
                    y_next = '0;
                else if (h_val > H_ONE)
                    y_next = H_ONE[OUT_W-1:0];
                else
                    y_next = h_val[OUT_W-1:0];
            end
            default: y_next = sat_s;
        endcase
    end

    // Accumulate the product of the data returned for last cycle's read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_d_reg    <= 1'b0;
            first_d_reg <= 1'b0;
            acc_reg     <= '0;
        end else begin
            rd_d_reg    <= fetch;
            first_d_reg <= fetch && (i_reg == '0);
            if (rd_d_reg)
                acc_reg <= first_d_reg ? (bias_q + prod_ext) : (acc_reg + prod_ext);
        end
    end

    // Run sequencing: fetch / drain / activate / output per column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            c_reg      <= '0;
            i_reg      <= '0;
            mode_reg   <= '0;
            bias_reg   <= '0;
            y_col_reg  <= '0;
            y_data_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        mode_reg  <= mode;
                        bias_reg  <= bias;
                        c_reg     <= '0;
                        i_reg     <= '0;
                        state_reg <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (i_reg == I_LAST) begin
                        i_reg     <= '0;
                        state_reg <= S_DRAIN;
                    end else begin
                        i_reg <= i_reg + 1'b1;
                    end
                end
                S_DRAIN: state_reg <= S_ACT;
                S_ACT: begin
                    y_data_reg <= y_next;
                    y_col_reg  <= c_reg;
                    state_reg  <= S_OUT;
                end
                S_OUT: begin
                    if (y_ready) begin
                        if (c_reg == C_LAST) begin
                            state_reg <= S_DONE;
                        end else begin
                            c_reg     <= c_reg + 1'b1;
                            state_reg <= S_FETCH;
                        end
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_dense_engine.sv
// Directed bench for nn_dense_engine with N_IN=4, N_COL=2.
module tb_nn_dense_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = '0;
    logic [11:0] bias = '0;
    logic        busy, done, x_rd, w_rd, y_valid, y_col;
    logic [2:0]  x_addr;
    logic [1:0]  w_addr;
    logic [7:0]  x_data;
    logic [11:0] w_data;
    logic        y_ready = 1'b1;
    logic [11:0] y_data;

    logic [7:0]  x_mem [0:7];
    logic [11:0] w_mem [0:3];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int t_run = 0;

    nn_dense_engine #(.N_IN(4), .N_COL(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .bias(bias),
        .busy(busy), .done(done),
        .x_rd(x_rd), .x_addr(x_addr), .x_data(x_data),
        .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_col(y_col), .y_data(y_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROMs with one cycle of latency
    always @(posedge clk) begin
        if (x_rd) x_data <= x_mem[x_addr];
        if (w_rd) w_data <= w_mem[w_addr];
    end

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        y_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, x_rd, w_rd, x_addr, w_addr, y_valid, y_col, y_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got %h want 0",
                     {busy, done, x_rd, w_rd, x_addr, w_addr, y_valid, y_col, y_data});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_case(input string name, input int x0, input int x1, input int w,
                            input int b, input int m, input int y0, input int y1,
                            input int stall);
        int t0;
        int k;
        int exp_y;
        int exp_t;
        logic [11:0] hold_data;
        for (int i = 0; i < 4; i++) begin
            x_mem[i]     = x0[7:0];
            x_mem[4 + i] = x1[7:0];
            w_mem[i]     = w[11:0];
        end
        @(negedge clk);
        bias = b[11:0];
        mode = m[1:0];
        y_ready = (stall == 0);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (!(busy === 1'b1 && x_rd === 1'b1 && x_addr === 3'd0 && w_addr === 2'd0)) begin
            bad++;
            $display("FAIL %s first_read got busy=%b x_rd=%b x_addr=%0d want 1 1 0", name, busy, x_rd, x_addr);
        end
        for (int col = 0; col < 2; col++) begin
            k = 0;
            while (y_valid !== 1'b1 && k < 40) begin
                @(negedge clk);
                k++;
            end
            total++;
            if (y_valid !== 1'b1) begin
                bad++;
                $display("FAIL %s col%0d y_valid timeout got 0 want 1", name, col);
                return;
            end
            exp_y = (col == 0) ? y0 : y1;
            exp_t = (col == 0) ? t0 + 7 : t0 + 14 + stall;
            $display("%s col=%0d y=%0d cycle=%0d", name, y_col, $signed(y_data), cyc - t0);
            total++;
            if (cyc !== exp_t) begin
                bad++;
                $display("FAIL %s col%0d valid_time got %0d want %0d", name, col, cyc - t0, exp_t - t0);
            end
            total++;
            if (y_col !== col[0]) begin
                bad++;
                $display("FAIL %s col%0d y_col got %0d want %0d", name, col, y_col, col);
            end
            total++;
            if (int'($signed(y_data)) !== exp_y) begin
                bad++;
                $display("FAIL %s col%0d y_data got %0d want %0d", name, col, $signed(y_data), exp_y);
            end
            if (col == 0 && stall > 0) begin
                hold_data = y_data;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    start = (s == 1);
                    total++;
                    if (!(y_valid === 1'b1 && y_data === hold_data && y_col === 1'b0 &&
                          x_rd === 1'b0 && x_addr === 3'd0)) begin
                        bad++;
                        $display("FAIL %s stall%0d got v=%b d=%0d c=%0d rd=%b want 1 %0d 0 0",
                                 name, s, y_valid, y_data, y_col, x_rd, hold_data);
                    end
                end
                start = 1'b0;
                y_ready = 1'b1;
            end
            @(negedge clk);
            total++;
            if (y_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s col%0d valid_after_handshake got %b want 0", name, col, y_valid);
            end
        end
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (!(done === 1'b1 && busy === 1'b0 && cyc == t0 + 15 + stall)) begin
            bad++;
            $display("FAIL %s done_time got done=%b busy=%b t=%0d want 1 0 %0d",
                     name, done, busy, cyc - t0, 15 + stall);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done_pulse got %b want 0", name, done);
        end
    endtask

    // Start held through the done cycle is accepted only once back in IDLE
    task automatic test_done_start();
        int k;
        for (int i = 0; i < 4; i++) begin
            x_mem[i] = 8'd128;
            x_mem[4 + i] = 8'd128;
            w_mem[i] = 12'd256;
        end
        @(negedge clk);
        mode = 2'd0;
        bias = '0;
        y_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL done_start_ignored busy got %b want 0", busy);
        end
        t_run = cyc;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL done_start_next busy got %b want 1", busy);
        end
        $display("done_start restart accepted at cycle %0d", t_run);
    endtask

    // Asynchronous reset during column-1 fetch, then a clean rerun
    task automatic test_reset_mid_run();
        while (cyc < t_run + 9) @(negedge clk);
        total++;
        if (!(x_rd === 1'b1 && x_addr === 3'd5 && w_addr === 2'd1)) begin
            bad++;
            $display("FAIL mid_run_addr got rd=%b x=%0d w=%0d want 1 5 1", x_rd, x_addr, w_addr);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, x_rd, w_rd, x_addr, w_addr, y_valid, y_col, y_data} !== '0) begin
            bad++;
            $display("FAIL mid_run_reset got %h want 0",
                     {busy, done, x_rd, w_rd, x_addr, w_addr, y_valid, y_col, y_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("mid_run_reset applied");
        run_case("after_reset", 64, 128, 256, 0, 0, 256, 512, 0);
    endtask

    initial begin
        test_reset();
        run_case("identity",     128, 128,   256,  0, 0,   512,   512, 0);
        run_case("cols_differ",  128,  64,   256,  0, 0,   512,   256, 0);
        run_case("neg_ident",    128, 128,  -256,  0, 0,  -512,  -512, 0);
        run_case("neg_relu",     128, 128,  -256,  0, 1,     0,     0, 0);
        run_case("neg_sigmoid",  128, 128,  -256,  0, 2,     0,     0, 0);
        run_case("pos_sigmoid",  128, 128,   256,  0, 2,   256,   256, 0);
        run_case("pos_relu",     128,  64,   256,  0, 1,   512,   256, 0);
        run_case("bias_ident",   128, 128,     0, 64, 0,    64,    64, 0);
        run_case("bias_sigmoid", 128, 128,     0, 64, 2,   144,   144, 0);
        run_case("sat_pos",      255, 255,  2047,  0, 0,  2047,  2047, 0);
        run_case("sat_neg",      255, 255, -2048,  0, 0, -2048, -2048, 0);
        run_case("sat_relu",     255, 255,  2047,  0, 1,  2047,  2047, 0);
        run_case("sat_sigmoid",  255, 255,  2047,  0, 2,   256,   256, 0);
        run_case("mode3_ident",  128, 128,  -256,  0, 3,  -512,  -512, 0);
        run_case("backpressure", 128, 128,   256,  0, 0,   512,   512, 5);
        test_done_start();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
